// File: rtl/fir_filter_tf_param.sv
// Parametrised transposed-form FIR with valid handshake, double-buffered coefficients,
// flush, and a rounded/saturated narrow output registered alongside the full-precision result.
module fir_filter_tf_param #(
   parameter int NUM_TAPS  = 170,
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int ACC_W     = DATA_W + COEF_W + $clog2(NUM_TAPS),
   parameter int OUT_W     = 16,
   parameter int OUT_SHIFT = 15,
   parameter int AW        = $clog2(NUM_TAPS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     flush,
   input  logic                     coef_wr_en,
   input  logic [AW-1:0]            coef_wr_addr,
   input  logic signed [COEF_W-1:0] coef_wr_data,
   input  logic                     coef_commit,
   output logic                     out_valid,
   output logic signed [ACC_W-1:0]  out_full,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_sat
);

   localparam int PROD_W  = DATA_W + COEF_W;
   localparam int RND_SH  = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
   localparam logic signed [ACC_W-1:0] ROUND_C =
      (OUT_SHIFT > 0) ? (ACC_W'(1) << RND_SH) : '0;
   localparam logic signed [ACC_W-1:0] MAX_C =
      {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_C =
      {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [COEF_W-1:0] r_shadow [NUM_TAPS];
   logic signed [COEF_W-1:0] r_active [NUM_TAPS];
   logic signed [ACC_W-1:0]  r_d      [1:NUM_TAPS-1];

   logic                     r_out_valid;
   logic signed [ACC_W-1:0]  r_out_full;
   logic signed [OUT_W-1:0]  r_out_data;
   logic                     r_out_sat;

   logic signed [PROD_W-1:0] w_mul  [NUM_TAPS];
   logic signed [ACC_W-1:0]  w_prod [NUM_TAPS];
   logic signed [ACC_W-1:0]  w_full_next;
   logic signed [ACC_W-1:0]  w_rounded;
   logic signed [ACC_W-1:0]  w_shifted;
   logic signed [OUT_W-1:0]  w_narrow;
   logic                     w_sat;
   logic                     w_accept;

   assign w_accept = in_valid & ~flush;

   // One dedicated multiplier per tap, sign-extended to the accumulator width.
   for (genvar g = 0; g < NUM_TAPS; g++) begin : g_mul
      assign w_mul[g]  = in_data * r_active[g];
      assign w_prod[g] = ACC_W'(w_mul[g]);
   end

   assign w_full_next = r_d[1] + w_prod[0];
   assign w_rounded   = w_full_next + ROUND_C;
   assign w_shifted   = w_rounded >>> OUT_SHIFT;

   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latch inferred.
      w_narrow = w_shifted[OUT_W-1:0];
      w_sat    = 1'b0;
      if (w_shifted > MAX_C) begin
         w_narrow = MAX_C[OUT_W-1:0];
         w_sat    = 1'b1;
      end else if (w_shifted < MIN_C) begin
         w_narrow = MIN_C[OUT_W-1:0];
         w_sat    = 1'b1;
      end
   end

   // Commit samples the shadow before a coincident write lands (old value on the right-hand side).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: coefficient banks are small register files that must read zero after reset, so they are reset explicitly.
         for (int i = 0; i < NUM_TAPS; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         if (coef_commit) begin
            for (int i = 0; i < NUM_TAPS; i++) r_active[i] <= r_shadow[i];
         end
         if (coef_wr_en) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
               if (coef_wr_addr == AW'(i)) r_shadow[i] <= coef_wr_data;
            end
         end
      end
   end

   // Partial-sum chain: advances only on accepted samples; flush wins over in_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NUM_TAPS; i++) r_d[i] <= '0;
      end else if (flush) begin
         for (int i = 1; i < NUM_TAPS; i++) r_d[i] <= '0;
      end else if (in_valid) begin
         // NOTE: non-blocking updates make each tap read its neighbour's pre-edge value.
         r_d[NUM_TAPS-1] <= w_prod[NUM_TAPS-1];
         for (int i = 1; i <= NUM_TAPS-2; i++) r_d[i] <= r_d[i+1] + w_prod[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_full  <= '0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
      end else begin
         r_out_valid <= w_accept;
         if (w_accept) begin
            r_out_full <= w_full_next;
            r_out_data <= w_narrow;
            r_out_sat  <= w_sat;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_full  = r_out_full;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_fir_filter_tf_param.sv
// Bench for fir_filter_tf_param: two 4-tap instances (no shift / shift 15) share stimulus;
// expected full-precision results are queued when a sample is driven and checked when out_valid rises.
module tb_fir_filter_tf_param;

   localparam int N     = 4;
   localparam int DW    = 16;
   localparam int CW    = 16;
   localparam int AW    = 3;
   localparam int ACC_W = DW + CW + $clog2(N);
   localparam int OW    = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic in_valid, flush, coef_wr_en, coef_commit;
   logic signed [DW-1:0] in_data;
   logic [AW-1:0]        coef_wr_addr;
   logic signed [CW-1:0] coef_wr_data;

   logic                    out_valid_a, out_sat_a, out_valid_b, out_sat_b;
   logic signed [ACC_W-1:0] out_full_a, out_full_b;
   logic signed [OW-1:0]    out_data_a, out_data_b;

   int tests  = 0;
   int failed = 0;
   longint sb[$];

   always #5 clk = ~clk;

   fir_filter_tf_param #(.NUM_TAPS(N), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW),
                         .OUT_SHIFT(0), .AW(AW)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .flush(flush),
      .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
      .coef_commit(coef_commit), .out_valid(out_valid_a), .out_full(out_full_a),
      .out_data(out_data_a), .out_sat(out_sat_a));

   fir_filter_tf_param #(.NUM_TAPS(N), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW),
                         .OUT_SHIFT(15), .AW(AW)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .flush(flush),
      .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
      .coef_commit(coef_commit), .out_valid(out_valid_b), .out_full(out_full_b),
      .out_data(out_data_b), .out_sat(out_sat_b));

   function automatic void narrow(input longint full, input int sh,
                                  output longint r, output bit sat);
      longint v;
      v = full;
      if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
      v = v >>> sh;
      sat = 1'b1;
      if (v > 32767) r = 32767;
      else if (v < -32768) r = -32768;
      else begin
         r   = v;
         sat = 1'b0;
      end
   endfunction

   always @(negedge clk) begin
      longint e, ra, rb;
      bit     sa, sbt;
      if (rst_n && (out_valid_a || out_valid_b)) begin
         tests++;
         if (out_valid_a !== out_valid_b) begin
            failed++;
            $display("FAIL valid_match: a=%b b=%b", out_valid_a, out_valid_b);
         end
         tests++;
         if (sb.size() == 0) begin
            failed++;
            $display("FAIL unexpected_out_valid: got out_valid=1 with no sample pending, required 0");
         end else begin
            e = sb.pop_front();
            narrow(e, 0, ra, sa);
            narrow(e, 15, rb, sbt);
            if (out_full_a !== ACC_W'(e)) begin
               failed++;
               $display("FAIL full_a: got %0d required %0d", out_full_a, e);
            end
            tests++;
            if (out_full_b !== ACC_W'(e)) begin
               failed++;
               $display("FAIL full_b: got %0d required %0d", out_full_b, e);
            end
            tests++;
            if (out_data_a !== OW'(ra) || out_sat_a !== sa) begin
               failed++;
               $display("FAIL narrow_a: got %0d/%b required %0d/%b", out_data_a, out_sat_a, ra, sa);
            end
            tests++;
            if (out_data_b !== OW'(rb) || out_sat_b !== sbt) begin
               failed++;
               $display("FAIL narrow_b: got %0d/%b required %0d/%b", out_data_b, out_sat_b, rb, sbt);
            end
         end
      end
   end

   // One clock of stimulus; inputs return to idle afterwards.
   task automatic cyc(input bit v, input logic signed [DW-1:0] x, input bit fl = 1'b0,
                      input bit wr = 1'b0, input logic [AW-1:0] a = '0,
                      input logic signed [CW-1:0] dat = '0, input bit cm = 1'b0);
      in_valid     = v;
      in_data      = x;
      flush        = fl;
      coef_wr_en   = wr;
      coef_wr_addr = a;
      coef_wr_data = dat;
      coef_commit  = cm;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_data = '0; flush = 1'b0; coef_wr_en = 1'b0;
      coef_wr_addr = '0; coef_wr_data = '0; coef_commit = 1'b0;
   endtask

   task automatic send(input logic signed [DW-1:0] x, input longint exp_full);
      sb.push_back(exp_full);
      cyc(1'b1, x);
   endtask

   task automatic idle();
      cyc(1'b0, '0);
   endtask

   task automatic load(input int c0, input int c1, input int c2, input int c3, input bit cm = 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1, 3'd0, CW'(c0));
      cyc(1'b0, '0, 1'b0, 1'b1, 3'd1, CW'(c1));
      cyc(1'b0, '0, 1'b0, 1'b1, 3'd2, CW'(c2));
      cyc(1'b0, '0, 1'b0, 1'b1, 3'd3, CW'(c3));
      if (cm) cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
   endtask

   task automatic check_zero(input string name);
      tests++;
      if (out_valid_a !== 1'b0 || out_full_a !== '0 || out_data_a !== '0 || out_sat_a !== 1'b0 ||
          out_valid_b !== 1'b0 || out_full_b !== '0 || out_data_b !== '0 || out_sat_b !== 1'b0) begin
         failed++;
         $display("FAIL %s: got a=%b/%0d/%0d/%b b=%b/%0d/%0d/%b required all 0", name,
                  out_valid_a, out_full_a, out_data_a, out_sat_a,
                  out_valid_b, out_full_b, out_data_b, out_sat_b);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; flush = 1'b0; coef_wr_en = 1'b0;
      coef_wr_addr = '0; coef_wr_data = '0; coef_commit = 1'b0;
      #12;
      check_zero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_impulse();
      load(1, 2, 3, 4);
      send(1, 1); send(0, 2); send(0, 3); send(0, 4);
      idle();
   endtask

   task automatic test_gaps();
      for (int k = 0; k < 4; k++) begin
         send((k == 0) ? 16'sd1 : 16'sd0, longint'(k + 1));
         for (int g = 0; g < 2; g++) begin
            idle();
            tests++;
            if (out_valid_a !== 1'b0 || out_full_a !== ACC_W'(k + 1)) begin
               failed++;
               $display("FAIL gap_hold: got valid=%b full=%0d required valid=0 full=%0d",
                        out_valid_a, out_full_a, k + 1);
            end
         end
      end
   endtask

   task automatic test_commit_switch();
      cyc(1'b0, '0, 1'b1);
      load(1, 1, 1, 1);
      load(2, 0, 0, 0, 1'b0);
      send(10, 10);
      sb.push_back(20);
      cyc(1'b1, 10, 1'b0, 1'b0, '0, '0, 1'b1);
      send(10, 40);
      idle();
      cyc(1'b0, '0, 1'b1);
   endtask

   task automatic test_saturation();
      load(32767, 0, 0, 0);
      send(16'sh7FFF, 64'h3FFF0001);
      tests++;
      if (out_full_b !== ACC_W'(64'h3FFF0001) || out_data_b !== 16'h7FFE || out_sat_b !== 1'b0) begin
         failed++;
         $display("FAIL round_max: got %0h/%0h/%b required 3fff0001/7ffe/0", out_full_b, out_data_b, out_sat_b);
      end
      load(-32768, 0, 0, 0);
      send(-16'sd32768, longint'(1) <<< 30);
      tests++;
      if (out_data_b !== 16'h7FFF || out_sat_b !== 1'b1) begin
         failed++;
         $display("FAIL sat_pos: got %0h/%b required 7fff/1", out_data_b, out_sat_b);
      end
      send(16'sh7FFF, -32768 * 32767);
      idle();
   endtask

   task automatic test_flush_reset();
      load(1, 2, 3, 4);
      send(1, 1); send(0, 2);
      cyc(1'b1, 7, 1'b1);
      tests++;
      if (out_full_a !== ACC_W'(2)) begin
         failed++;
         $display("FAIL flush_hold: got %0d required 2", out_full_a);
      end
      send(0, 0); send(0, 0);
      idle();
      send(1, 1);
      idle();
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(5, 0); send(0, 0);
      idle();
   endtask

   task automatic test_oob_and_wr_commit();
      load(1, 2, 3, 4);
      cyc(1'b0, '0, 1'b0, 1'b1, 3'd4, 16'sd9);
      cyc(1'b0, '0, 1'b0, 1'b1, 3'd7, 16'sd9);
      cyc(1'b0, '0, 1'b0, 1'b1, 3'd0, 16'sd5, 1'b1);
      send(1, 1); send(0, 2); send(0, 3); send(0, 4);
      cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
      send(1, 5); send(0, 2); send(0, 3); send(0, 4);
      idle();
   endtask

   task automatic test_back_to_back();
      int     c [N];
      longint h [N];
      longint acc;
      c[0] = 3; c[1] = -5; c[2] = 7; c[3] = -2;
      for (int k = 0; k < N; k++) h[k] = 0;
      cyc(1'b0, '0, 1'b1);
      load(c[0], c[1], c[2], c[3]);
      for (int n = 0; n < 40; n++) begin
         logic signed [DW-1:0] x;
         x = DW'($urandom);
         for (int k = N - 1; k > 0; k--) h[k] = h[k-1];
         h[0] = longint'(x);
         acc = 0;
         for (int k = 0; k < N; k++) acc += longint'(c[k]) * h[k];
         send(x, acc);
      end
      idle();
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_impulse();
      test_gaps();
      test_commit_switch();
      test_saturation();
      test_flush_reset();
      test_oob_and_wr_commit();
      test_back_to_back();
      tests++;
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL missing_outputs: %0d pending, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
